// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Pipeline register between instruction decode and execute. Captures the
//   decoded operands, registers an ALU opcode derived from alu_op/funct3/
//   funct7_b5, and presents ALU operands to EX through a valid/ready
//   handshake. A saturating counter records cycles spent back-pressured.
//
// Configuration macro:
//   ID_EX_FORWARDING_EN - when defined, operand a and store_data are bypassed
//                         from EX/MEM (highest priority) or MEM/WB results.
//                         When undefined the exmem_*/memwb_* inputs are ignored.
//
// Ports:
//   clk, reset_n                    clock (rising edge), async active-low reset
//   in_valid / in_ready             decode-side handshake
//   rs1_data, rs2_data, imm         register-file reads and sign-extended imm
//   rs1, rs2, rd                    register indices
//   alu_src                         1 = operand b taken from imm
//   alu_op, funct3, funct7_b5       ALU decode inputs
//   flush                           kills the held instruction and any capture
//   exmem_*, memwb_*                forwarding sources
//   out_valid / out_ready           EX-side handshake
//   a, b, alu_ctl, store_data       ALU operands / opcode, store data
//   rd_out                          destination register
//   stall_cnt                       saturating back-pressure cycle count
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic [63:0] imm,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic        memwb_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [63:0] exmem_result,
    input  logic [63:0] memwb_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [3:0]  alu_ctl,
    output logic [63:0] store_data,
    output logic [4:0]  rd_out,
    output logic [15:0] stall_cnt
);

    logic        out_valid_q, out_valid_d;
    logic [63:0] rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        alu_src_q;
    logic [3:0]  alu_ctl_q, alu_ctl_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        capture;
    logic [63:0] a_fwd, sd_fwd;

    assign in_ready = !out_valid_q || out_ready;
    // A flush in the same cycle suppresses the capture entirely.
    assign capture  = in_valid && in_ready && !flush;

    // ALU opcode decode; unlisted R-type funct3 values map to 1111 (ALU yields 0).
    always_comb begin
        alu_ctl_d = 4'b1111;
        case (alu_op)
            2'b00: alu_ctl_d = 4'b0010;
            2'b01: alu_ctl_d = 4'b0110;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_ctl_d = funct7_b5 ? 4'b0110 : 4'b0010;
                    3'b111:  alu_ctl_d = 4'b0000;
                    3'b110:  alu_ctl_d = 4'b0001;
                    default: alu_ctl_d = 4'b1111;
                endcase
            end
            default: alu_ctl_d = 4'b1111;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (capture)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_src_q   <= 1'b0;
            alu_ctl_q   <= 4'b0000;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            // Fields only load on capture, which cannot happen while stalled,
            // so they stay stable under back-pressure.
            if (capture) begin
                rs1_data_q <= rs1_data;
                rs2_data_q <= rs2_data;
                imm_q      <= imm;
                rs1_q      <= rs1;
                rs2_q      <= rs2;
                rd_q       <= rd;
                alu_src_q  <= alu_src;
                alu_ctl_q  <= alu_ctl_d;
            end
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // x0 is never forwarded; EX/MEM is newer than MEM/WB and wins.
    always_comb begin
        a_fwd = rs1_data_q;
        if (exmem_regwrite && exmem_rd == rs1_q && rs1_q != 5'd0)
            a_fwd = exmem_result;
        else if (memwb_regwrite && memwb_rd == rs1_q && rs1_q != 5'd0)
            a_fwd = memwb_result;
    end

    always_comb begin
        sd_fwd = rs2_data_q;
        if (exmem_regwrite && exmem_rd == rs2_q && rs2_q != 5'd0)
            sd_fwd = exmem_result;
        else if (memwb_regwrite && memwb_rd == rs2_q && rs2_q != 5'd0)
            sd_fwd = memwb_result;
    end
`else
    assign a_fwd  = rs1_data_q;
    assign sd_fwd = rs2_data_q;

    // Forwarding sources and register indices have no consumer in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                                 exmem_result, memwb_result, rs1_q, rs2_q};
`endif

    assign out_valid  = out_valid_q;
    assign a          = a_fwd;
    assign store_data = sd_fwd;
    assign b          = alu_src_q ? imm_q : sd_fwd;
    assign alu_ctl    = alu_ctl_q;
    assign rd_out     = rd_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [63:0] a, b, store_data;
    logic [3:0]  alu_ctl;
    logic [4:0]  rd_out;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5),
        .flush(flush),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .alu_ctl(alu_ctl), .store_data(store_data),
        .rd_out(rd_out), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        b5;
        logic        src;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic        exw, mww;
        logic [4:0]  exrd, mwrd;
        logic [63:0] exres, mwres;
        logic [3:0]  e_ctl;
        logic [63:0] e_a, e_af, e_sd, e_sdf;   // expected without / with forwarding
    } vec_t;

    typedef struct {
        logic [3:0]  ctl;
        logic [63:0] a, b, sd;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                                input logic src, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rdx, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [63:0] im, input logic [3:0] ctl,
                                input logic [63:0] ea, input logic [63:0] eaf,
                                input logic [63:0] esd, input logic [63:0] esdf);
        vec_t v;
        v.op = op; v.f3 = f3; v.b5 = b5; v.src = src;
        v.rs1 = r1; v.rs2 = r2; v.rd = rdx;
        v.d1 = d1; v.d2 = d2; v.imm = im;
        v.exw = 1'b0; v.mww = 1'b0; v.exrd = '0; v.mwrd = '0; v.exres = '0; v.mwres = '0;
        v.e_ctl = ctl; v.e_a = ea; v.e_af = eaf; v.e_sd = esd; v.e_sdf = esdf;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        alu_op = v.op; funct3 = v.f3; funct7_b5 = v.b5; alu_src = v.src;
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        rs1_data = v.d1; rs2_data = v.d2; imm = v.imm;
        exmem_regwrite = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
        memwb_regwrite = v.mww; memwb_rd = v.mwrd; memwb_result = v.mwres;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.ctl = v.e_ctl;
        e.a   = FWD_ON ? v.e_af : v.e_a;
        e.sd  = FWD_ON ? v.e_sdf : v.e_sd;
        e.b   = v.src ? v.imm : e.sd;
        e.rd  = v.rd;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk); #1;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted output is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: actual rd_out=%0d required no output", rd_out);
            end else begin
                e = sb_q.pop_front();
                $display("xfer rd=%0d alu_ctl=%b a=%h b=%h sd=%h", rd_out, alu_ctl, a, b, store_data);
                check("alu_ctl", alu_ctl, e.ctl);
                check("a", a, e.a);
                check("b", b, e.b);
                check("store_data", store_data, e.sd);
                check("rd_out", rd_out, e.rd);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                op     f3      b5   src  rs1 rs2 rd  d1       d2      imm                    ctl      e_a      e_af     e_sd    e_sdf
        vt[0]  = mk(2'b00, 3'b000, 1'b0, 1'b0, 1,  2,  3, 64'd10,  64'd3,  64'd0,                 4'b0010, 64'd10,  64'd10,  64'd3,  64'd3);
        vt[1]  = mk(2'b01, 3'b000, 1'b0, 1'b1, 3,  4,  5, 64'd100, 64'd7,  64'hFFFF_FFFF_FFFF_FFFB, 4'b0110, 64'd100, 64'd100, 64'd7,  64'd7);
        vt[2]  = mk(2'b11, 3'b010, 1'b0, 1'b0, 6,  7,  8, 64'h1234, 64'h5678, 64'd0,              4'b1111, 64'h1234, 64'h1234, 64'h5678, 64'h5678);
        vt[3]  = mk(2'b10, 3'b000, 1'b0, 1'b0, 1,  2,  9, 64'd20,  64'd4,  64'd0,                 4'b0010, 64'd20,  64'd20,  64'd4,  64'd4);
        vt[4]  = mk(2'b10, 3'b000, 1'b1, 1'b0, 1,  2, 10, 64'd10,  64'd3,  64'd0,                 4'b0110, 64'd10,  64'd10,  64'd3,  64'd3);
        vt[5]  = mk(2'b10, 3'b111, 1'b0, 1'b0, 11, 12, 13, 64'hF0,  64'h3C, 64'd0,                4'b0000, 64'hF0,  64'hF0,  64'h3C, 64'h3C);
        vt[6]  = mk(2'b10, 3'b110, 1'b0, 1'b1, 14, 15, 16, 64'hA5,  64'h5A, 64'h77,               4'b0001, 64'hA5,  64'hA5,  64'h5A, 64'h5A);
        vt[7]  = mk(2'b10, 3'b100, 1'b0, 1'b0, 17, 18, 19, 64'd1,   64'd2,  64'd0,                4'b1111, 64'd1,   64'd1,   64'd2,  64'd2);
        vt[8]  = mk(2'b10, 3'b001, 1'b1, 1'b0, 20, 21, 22, 64'd5,   64'd6,  64'd0,                4'b1111, 64'd5,   64'd5,   64'd6,  64'd6);
        vt[9]  = mk(2'b00, 3'b000, 1'b0, 1'b0, 5,  6, 23, 64'h11,   64'h66, 64'd0,                4'b0010, 64'h11,  64'hAA,  64'h66, 64'h66);
        vt[9].exw = 1'b1; vt[9].exrd = 5'd5; vt[9].exres = 64'hAA;
        vt[9].mww = 1'b1; vt[9].mwrd = 5'd5; vt[9].mwres = 64'hBB;
        vt[10] = mk(2'b00, 3'b000, 1'b0, 1'b0, 0,  0, 24, 64'h33,   64'h44, 64'd0,                4'b0010, 64'h33,  64'h33,  64'h44, 64'h44);
        vt[10].exw = 1'b1; vt[10].exrd = 5'd0; vt[10].exres = 64'hAA;
        vt[10].mww = 1'b1; vt[10].mwrd = 5'd0; vt[10].mwres = 64'hBB;
        vt[11] = mk(2'b00, 3'b000, 1'b0, 1'b0, 2,  7, 25, 64'h22,   64'h77, 64'd0,                4'b0010, 64'h22,  64'h22,  64'h77, 64'hCC);
        vt[11].exw = 1'b1; vt[11].exrd = 5'd3; vt[11].exres = 64'hE3;
        vt[11].mww = 1'b1; vt[11].mwrd = 5'd7; vt[11].mwres = 64'hCC;
        vt[12] = mk(2'b00, 3'b000, 1'b0, 1'b0, 9,  1, 26, 64'hD1,   64'h5,  64'd0,                4'b0010, 64'hD1,  64'h99,  64'h5,  64'h5);
        vt[12].exw = 1'b0; vt[12].exrd = 5'd9; vt[12].exres = 64'h1;
        vt[12].mww = 1'b1; vt[12].mwrd = 5'd9; vt[12].mwres = 64'h99;

        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive_vec(vt[0]);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_alu_ctl", alu_ctl, 4'b0000);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_rd_out", rd_out, 0);
        check("reset_in_ready", in_ready, 1);
        do_reset();

        // Table vectors, one transaction at a time.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive_vec(vt[i]);
            in_valid = 1'b1;
            push_exp(vt[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("out_valid_after_capture", out_valid, 1);
            wait_drain("vec_drain");
        end

        // Back-to-back transfers at full rate.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            drive_vec(vt[i]);
            in_valid = 1'b1;
            push_exp(vt[i]);
            check("b2b_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain");

        // Back-pressure: hold for 4 cycles with a new instruction waiting.
        do_reset();
        out_ready = 1'b0;
        drive_vec(vt[4]);
        in_valid = 1'b1;
        push_exp(vt[4]);
        @(posedge clk); #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready_low", in_ready, 0);
        drive_vec(vt[5]);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("bp_stall_cnt4", stall_cnt, 4);
        check("bp_in_ready_still_low", in_ready, 0);
        check("bp_hold_alu_ctl", alu_ctl, 4'b0110);
        check("bp_hold_a", a, 64'd10);
        check("bp_hold_b", b, 64'd3);
        check("bp_hold_rd", rd_out, 10);
        push_exp(vt[5]);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_stall_cnt_after", stall_cnt, 4);
        wait_drain("bp_drain");

        // Flush racing a capture.
        @(posedge clk); #1;
        drive_vec(vt[6]);
        in_valid = 1'b1;
        flush = 1'b1;
        check("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("flush_kills_capture", out_valid, 0);
        in_valid = 1'b0;
        flush = 1'b0;

        // Flush of a held instruction.
        out_ready = 1'b0;
        drive_vec(vt[7]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_out_valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_held", out_valid, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("flush_held_stays_empty", out_valid, 0);

        // Reset mid-transfer drops the held instruction.
        out_ready = 1'b0;
        drive_vec(vt[1]);
        in_valid = 1'b1;
        push_exp(vt[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_alu_ctl", alu_ctl, 4'b0000);
        check("midrst_stall_cnt", stall_cnt, 0);
        check("midrst_a", a, 0);
        check("midrst_rd_out", rd_out, 0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("postrst_no_stale1", out_valid, 0);
        @(negedge clk);
        check("postrst_no_stale2", out_valid, 0);

        // Stall counter saturation.
        do_reset();
        out_ready = 1'b0;
        drive_vec(vt[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("stall_cnt_fffe", stall_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("stall_cnt_saturate", stall_cnt, 16'hFFFF);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        check("sat_flush_clear", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1; in_ready  out  1  (decode-side handshake).
REQ-004 SHALL have: rs1_data, rs2_data, imm  in  64 each  (register-file reads, sign-extended immediate).
REQ-005 SHALL have: rs1, rs2, rd  in  5 each; alu_src  in  1 (1 = b from imm); alu_op  in  2; funct3  in  3; funct7_b5  in  1 (instr[30]).
REQ-006 SHALL have: flush  in  1  (kill held instruction).
REQ-007 SHALL have: exmem_regwrite, memwb_regwrite  in  1; exmem_rd, memwb_rd  in  5; exmem_result, memwb_result  in  64.
REQ-008 SHALL have: out_valid  out  1; out_ready  in  1 (EX-side handshake).
REQ-009 SHALL have: a, b  out  64 (ALU operands); alu_ctl  out  4 (ALU opcode); store_data  out  64; rd_out  out  5.
REQ-010 SHALL have: stall_cnt  out  16  (saturating count of back-pressure cycles).

Function
REQ-011 SHALL assert in_ready = !out_valid || out_ready, combinationally.
REQ-012 SHALL capture all inputs on a rising edge where in_valid && in_ready and not flush; out_valid=1 next cycle.
REQ-013 SHALL clear out_valid on an edge with out_ready && out_valid and no capture; latency in->out exactly 1 cycle; back-to-back transfers at full rate.
REQ-014 SHALL, when flush=1 at an edge, set out_valid=0 and discard any same-cycle capture (flush wins).
REQ-015 SHALL hold all registered fields stable while out_valid && !out_ready.
REQ-016 SHALL decode alu_ctl at capture: alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 1111.
REQ-017 SHALL decode alu_op 10 as: funct3 000 & b5=0 -> 0010; 000 & b5=1 -> 0110; 111 -> 0000; 110 -> 0001; any other -> 1111 (illegal; ALU returns 0).
REQ-018 SHALL compute a = fwd(rs1_q, rs1_data_q); store_data = fwd(rs2_q, rs2_data_q); b = alu_src_q ? imm_q : store_data; combinationally from registered values.
REQ-019 fwd(r, d) SHALL return exmem_result if exmem_regwrite && exmem_rd==r && r!=0; else memwb_result if memwb_regwrite && memwb_rd==r && r!=0; else d (EX/MEM priority over MEM/WB).
REQ-020 SHALL drive rd_out = rd_q.
REQ-021 SHALL increment stall_cnt on every edge with out_valid && !out_ready, saturating at 16'hFFFF.

Reset
REQ-022 SHALL, while reset_n=0, immediately force out_valid=0, all data/control registers to 0 (alu_ctl_q=0000, rd_q=0), stall_cnt=0.
REQ-023 SHALL, on reset asserted mid-transfer, drop the held instruction without emitting it; first capture occurs on the first edge after reset_n rises.

Configuration
REQ-024 SHALL implement forwarding only when macro ID_EX_FORWARDING_EN is defined.
REQ-025 Without ID_EX_FORWARDING_EN, fwd(r, d) SHALL return d; exmem_*/memwb_* inputs SHALL be ignored; all other behaviour unchanged.

Verification
REQ-026 Reset: reset_n=0 mid-stream -> out_valid=0, alu_ctl=0000, stall_cnt=0 same cycle, no stale output after release.
REQ-027 Decode: alu_op=10, funct3=000, b5=1, rs1_data=10, rs2_data=3, alu_src=0 -> next cycle out_valid=1, alu_ctl=0110, a=10, b=3; funct3=111 -> 0000; funct3=100 -> 1111.
REQ-028 Forwarding (macro on): rs1=5, exmem_regwrite=1, exmem_rd=5, exmem_result=64'hAA, memwb_rd=5, memwb_result=64'hBB -> a=64'hAA; rs1=0 with both matching -> a=rs1_data_q; macro off -> a=rs1_data_q.
REQ-029 Back-pressure: out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, outputs stable, stall_cnt increments by 4; then out_ready=1 -> transfer, in_ready=1.
REQ-030 Flush: in_valid=1, in_ready=1, flush=1 same edge -> out_valid=0 next cycle; stall_cnt preset to 16'hFFFE, 3 stall cycles -> 16'hFFFF.
